tempsense_sar_ctrl: RTL and testbench
=====================================

TEMPSENSE_SAR_CTRL -- requirements
Module: tempsense_sar_ctrl

Interface
REQ-001 Parameter N_VDAC, 6, DAC code width; codes 0..2**N_VDAC-1, VMAX = all ones.
REQ-002 Parameter N_CH, 2, number of external tempsense delay cells, N_CH >= 2.
REQ-003 Parameter N_AVG_LOG2, 2, log2 of conversions averaged per request; 0 means no averaging.
REQ-004 clk  in  1  system clock.
REQ-005 reset  in  1  reset, synchronous, active-high; clock clk.
REQ-006 start  in  1  conversion request, sampled only when busy=0.
REQ-007 mode  in  1  search mode: 0 = linear descending sweep, 1 = SAR binary search.
REQ-008 ch_sel  in  $clog2(N_CH)  channel to measure.
REQ-009 cal_ena  in  1  apply calibration LUT to result.
REQ-010 cal_we / cal_addr / cal_wdata  in  1 / N_VDAC / N_VDAC  LUT write port.
REQ-011 tempdelay  in  N_CH  delay-cell outputs, sampled directly without a synchronizer.
REQ-012 dac_data  out  N_VDAC  shared DAC code to the cells.
REQ-013 dac_en  out  N_CH  per-cell enable, one-hot.
REQ-014 precharge_n  out  1  0 = precharge, 1 = measure.
REQ-015 busy / done / result / out_of_range  out  1 / 1 / N_VDAC / 1  status, one-cycle completion pulse, result, no-edge flag.

Function
REQ-016 mode, ch_sel and cal_ena are latched on the edge that accepts start; start while busy=1 is ignored.
REQ-017 busy rises the cycle after acceptance and stays high until the done cycle.
REQ-018 Each trial takes 4 cycles:
- PRE: dac_data=VMAX, precharge_n=0.
- TRANS: dac_data=0, precharge_n=0.
- MEAS: dac_data=trial code, precharge_n=1.
- EVAL: dac_data=trial code, precharge_n=1; d = tempdelay[ch] is sampled at the edge ending EVAL.
REQ-019 Linear mode:
- Trial codes run VMAX, VMAX-1, ... down to 0.
- The conversion ends at the first trial with d=1; its code is the conversion value.
- If all 2**N_VDAC trials give d=0, the value is 0 and the no-edge condition is set.
REQ-020 SAR mode:
- acc starts at 0; for each bit b from MSB to LSB, trial = acc | (1<<b).
- If d=1, acc takes the trial code.
- Exactly N_VDAC trials run; the value is the final acc.
- The no-edge condition is set if no trial gave d=1.
REQ-021 2**N_AVG_LOG2 conversions run back to back.
- Values are summed in an (N_VDAC+N_AVG_LOG2)-bit accumulator, which cannot overflow.
- Averaged value = sum >> N_AVG_LOG2 (truncation).
REQ-022 out_of_range = 1 only if the no-edge condition held in every averaged conversion.
REQ-023 Completion occurs on the edge ending the last EVAL: done=1 for one cycle, busy=0 in that same cycle, and result/out_of_range update.
REQ-024 result and out_of_range hold until the next done.
REQ-025 result = LUT[averaged value] if the latched cal_ena=1, else the averaged value.
REQ-026 If cal_we coincides with the done edge, the lookup uses the pre-write LUT content; writes during busy are permitted.
REQ-027 dac_en[ch] = 1 only while busy; all dac_en bits are 0 while idle.
REQ-028 In idle, dac_data=VMAX and precharge_n=0.
REQ-029 A new start may be accepted in the done cycle; back-to-back requests are therefore legal.

Reset
REQ-030 reset aborts any conversion in progress; the next cycle has busy=0, done=0, dac_en=0, dac_data=VMAX, precharge_n=0, result=0, out_of_range=0.
REQ-031 reset preloads the LUT to identity (LUT[i]=i) and clears all internal counters and accumulators.

Structure
REQ-032 Package tempsense_pkg shall hold:
- the phase enum (PRE/TRANS/MEAS/EVAL);
- the controller state enum (IDLE/RUN/DONE);
- the MODE_LINEAR and MODE_SAR constants.
REQ-033 The calibration LUT shall be a sub-module tempsense_cal_lut with a registered write and a combinational read.
REQ-034 The delay cells stay outside this block.

Verification (cell model for REQ-035 to REQ-039: d = (code <= T); defaults unless stated)
REQ-035 SAR, T=37, cal_ena=0 -> busy for 96 cycles (4 trials × 6 bits × 4 conversions); done; result=37, out_of_range=0.
REQ-036 Linear, T=37 -> 27 trials per conversion, busy for 432 cycles; result=37.
REQ-037 Linear and SAR, d held at 0 -> result=0, out_of_range=1; dac_en one-hot on ch_sel=1 throughout busy.
REQ-038 SAR, T=36,37,38,39 across the four conversions -> sum=150, result=37; a start pulse mid-conversion is ignored.
REQ-039 cal_ena=1 with LUT[37]=20 written during busy -> result=20.
REQ-040 Reset asserted mid-conversion -> busy=0, dac_en=0, result=0 the next cycle.

Source files
------------

// File: rtl/tempsense_pkg.sv
// Shared types and constants for the temperature-sensor SAR controller.
//   phase_t      : four-cycle trial phases (precharge, transition, measure, evaluate)
//   ctrl_state_t : controller states
//   MODE_LINEAR / MODE_SAR : values of the mode input
package tempsense_pkg;

  typedef enum logic [1:0] {
    PH_PRE   = 2'd0,
    PH_TRANS = 2'd1,
    PH_MEAS  = 2'd2,
    PH_EVAL  = 2'd3
  } phase_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } ctrl_state_t;

  localparam logic MODE_LINEAR = 1'b0;
  localparam logic MODE_SAR    = 1'b1;

endpackage

// File: rtl/tempsense_cal_lut.sv
// Calibration look-up table: maps an averaged DAC code to a corrected code.
// Registered write port, combinational read port. Reset loads identity.
//   clk, reset      : clock, synchronous active-high reset
//   we/waddr/wdata  : write port
//   raddr/rdata     : asynchronous read port
module tempsense_cal_lut #(
  parameter int N_VDAC = 6
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              we,
  input  logic [N_VDAC-1:0] waddr,
  input  logic [N_VDAC-1:0] wdata,
  input  logic [N_VDAC-1:0] raddr,
  output logic [N_VDAC-1:0] rdata
);

  localparam int DEPTH = 1 << N_VDAC;

  logic [N_VDAC-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= N_VDAC'(i);
    end else if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/tempsense_sar_ctrl.sv
// Temperature-sensor conversion controller. Drives a shared DAC and one-hot
// cell enables to external delay cells, searches for the DAC code at which the
// selected cell's output flips (linear sweep or SAR), averages several
// conversions and optionally maps the result through a calibration LUT.
//   clk, reset                    : clock, synchronous active-high reset
//   start, mode, ch_sel, cal_ena  : request and its configuration
//   cal_we, cal_addr, cal_wdata   : calibration LUT write port
//   tempdelay                     : delay-cell outputs (unsynchronized)
//   dac_data, dac_en, precharge_n : cell drive
//   busy, done, result, out_of_range : status
//
// state   | meaning
// IDLE    | waiting for start, cells precharged and disabled
// RUN     | trials in progress (busy=1)
// DONE    | one-cycle completion pulse; may accept a new start
module tempsense_sar_ctrl
  import tempsense_pkg::*;
#(
  parameter int N_VDAC     = 6,
  parameter int N_CH       = 2,
  parameter int N_AVG_LOG2 = 2
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic                    mode,
  input  logic [$clog2(N_CH)-1:0] ch_sel,
  input  logic                    cal_ena,
  input  logic                    cal_we,
  input  logic [N_VDAC-1:0]       cal_addr,
  input  logic [N_VDAC-1:0]       cal_wdata,
  input  logic [N_CH-1:0]         tempdelay,
  output logic [N_VDAC-1:0]       dac_data,
  output logic [N_CH-1:0]         dac_en,
  output logic                    precharge_n,
  output logic                    busy,
  output logic                    done,
  output logic [N_VDAC-1:0]       result,
  output logic                    out_of_range
);

  localparam int CHW = $clog2(N_CH);
  localparam int BW  = (N_VDAC > 1) ? $clog2(N_VDAC) : 1;
  localparam int SW  = N_VDAC + N_AVG_LOG2;
  localparam int CW  = (N_AVG_LOG2 > 0) ? N_AVG_LOG2 : 1;
  localparam logic [CW-1:0]     CONV_LAST = CW'((1 << N_AVG_LOG2) - 1);
  localparam logic [N_VDAC-1:0] VMAX      = '1;
  localparam logic [BW-1:0]     MSB_IDX   = BW'(N_VDAC - 1);

  ctrl_state_t state, state_nx;
  phase_t      phase, phase_nx;

  logic              mode_q;
  logic [CHW-1:0]    ch_q;
  logic              cal_q;
  // Linear mode: current trial code. SAR mode: accumulated result bits.
  logic [N_VDAC-1:0] acc;
  logic [BW-1:0]     bidx;
  logic              hit;
  logic [CW-1:0]     conv_cnt;
  logic [SW-1:0]     sum;
  logic              noedge_all;

  logic              accept;
  logic              d;
  logic [N_VDAC-1:0] trial;
  logic              eval_end;
  logic              conv_end;
  logic [N_VDAC-1:0] conv_val;
  logic              conv_noedge;
  logic [SW-1:0]     sum_fin;
  logic [N_VDAC-1:0] avg;
  logic [N_VDAC-1:0] lut_rdata;

  tempsense_cal_lut #(.N_VDAC(N_VDAC)) u_lut (
    .clk   (clk),
    .reset (reset),
    .we    (cal_we),
    .waddr (cal_addr),
    .wdata (cal_wdata),
    .raddr (avg),
    .rdata (lut_rdata)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_IDLE;
      phase <= PH_PRE;
    end else begin
      state <= state_nx;
      phase <= phase_nx;
    end
  end

  always_comb begin
    state_nx    = state;
    phase_nx    = PH_PRE;
    accept      = 1'b0;
    busy        = 1'b0;
    done        = 1'b0;
    dac_data    = VMAX;
    dac_en      = '0;
    precharge_n = 1'b0;
    d           = tempdelay[ch_q];
    trial       = (mode_q == MODE_SAR) ? (acc | (N_VDAC'(1) << bidx)) : acc;
    eval_end    = (state == ST_RUN) && (phase == PH_EVAL);
    conv_end    = 1'b0;
    conv_val    = '0;
    conv_noedge = 1'b0;

    if (mode_q == MODE_SAR) begin
      conv_end    = eval_end && (bidx == '0);
      conv_val    = d ? trial : acc;
      conv_noedge = !(hit || d);
    end else begin
      // Sweep stops on the first flip, or after the zero code with no flip.
      conv_end    = eval_end && (d || (acc == '0));
      conv_val    = d ? acc : '0;
      conv_noedge = !d;
    end

    sum_fin = sum + SW'(conv_val);
    avg     = N_VDAC'(sum_fin >> N_AVG_LOG2);

    case (state)
      ST_RUN: begin
        busy   = 1'b1;
        dac_en = N_CH'(1) << ch_q;
        case (phase)
          PH_PRE:   begin phase_nx = PH_TRANS; dac_data = VMAX; end
          PH_TRANS: begin phase_nx = PH_MEAS;  dac_data = '0;   end
          PH_MEAS:  begin phase_nx = PH_EVAL;  dac_data = trial; precharge_n = 1'b1; end
          default:  begin phase_nx = PH_PRE;   dac_data = trial; precharge_n = 1'b1; end
        endcase
        if (conv_end && (conv_cnt == CONV_LAST)) state_nx = ST_DONE;
      end
      default: begin
        done     = (state == ST_DONE);
        accept   = start;
        state_nx = start ? ST_RUN : ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      mode_q       <= MODE_LINEAR;
      ch_q         <= '0;
      cal_q        <= 1'b0;
      acc          <= '0;
      bidx         <= '0;
      hit          <= 1'b0;
      conv_cnt     <= '0;
      sum          <= '0;
      noedge_all   <= 1'b0;
      result       <= '0;
      out_of_range <= 1'b0;
    end else if (accept) begin
      mode_q     <= mode;
      ch_q       <= ch_sel;
      cal_q      <= cal_ena;
      acc        <= (mode == MODE_SAR) ? '0 : VMAX;
      bidx       <= MSB_IDX;
      hit        <= 1'b0;
      conv_cnt   <= '0;
      sum        <= '0;
      noedge_all <= 1'b1;
    end else if (conv_end) begin
      sum        <= sum_fin;
      noedge_all <= noedge_all & conv_noedge;
      conv_cnt   <= conv_cnt + 1'b1;
      acc        <= (mode_q == MODE_SAR) ? '0 : VMAX;
      bidx       <= MSB_IDX;
      hit        <= 1'b0;
      if (conv_cnt == CONV_LAST) begin
        // LUT read is combinational, so a write on this same edge is not seen.
        result       <= cal_q ? lut_rdata : avg;
        out_of_range <= noedge_all & conv_noedge;
      end
    end else if (eval_end) begin
      if (mode_q == MODE_SAR) begin
        if (d) acc <= trial;
        hit  <= hit | d;
        bidx <= bidx - 1'b1;
      end else begin
        acc <= acc - 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_tempsense_sar_ctrl.sv
module tb_tempsense_sar_ctrl;
  import tempsense_pkg::*;

  localparam int N_VDAC     = 6;
  localparam int N_CH       = 2;
  localparam int N_AVG_LOG2 = 2;
  localparam int N_CONV     = 1 << N_AVG_LOG2;
  localparam int VMAX       = (1 << N_VDAC) - 1;

  logic              clk = 1'b0;
  logic              reset;
  logic              start;
  logic              mode;
  logic [0:0]        ch_sel;
  logic              cal_ena;
  logic              cal_we;
  logic [N_VDAC-1:0] cal_addr;
  logic [N_VDAC-1:0] cal_wdata;
  logic [N_CH-1:0]   tempdelay;
  logic [N_VDAC-1:0] dac_data;
  logic [N_CH-1:0]   dac_en;
  logic              precharge_n;
  logic              busy;
  logic              done;
  logic [N_VDAC-1:0] result;
  logic              out_of_range;

  int checks = 0;
  int errors = 0;
  int cur_thr = -1;
  int thr_tab [N_CONV];
  int lut_m [1 << N_VDAC];

  tempsense_sar_ctrl #(.N_VDAC(N_VDAC), .N_CH(N_CH), .N_AVG_LOG2(N_AVG_LOG2)) dut (
    .clk(clk), .reset(reset), .start(start), .mode(mode), .ch_sel(ch_sel),
    .cal_ena(cal_ena), .cal_we(cal_we), .cal_addr(cal_addr), .cal_wdata(cal_wdata),
    .tempdelay(tempdelay), .dac_data(dac_data), .dac_en(dac_en),
    .precharge_n(precharge_n), .busy(busy), .done(done), .result(result),
    .out_of_range(out_of_range)
  );

  always #5 clk = ~clk;

  // Delay-cell model: an enabled cell reports 1 when the DAC code is at or below its threshold.
  always_comb begin
    tempdelay = '0;
    for (int i = 0; i < N_CH; i++)
      if (dac_en[i] && (int'(dac_data) <= cur_thr)) tempdelay[i] = 1'b1;
  end

  task automatic lut_model_reset();
    for (int i = 0; i <= VMAX; i++) lut_m[i] = i;
  endtask

  // One full request. wr_cycle: -1 none, 0 random busy cycle, -2 the last busy cycle.
  task automatic do_conv(input logic m, input int ch, input logic cal, input int wr_cycle_in,
                         input int wr_addr, input int wr_data, input int mid_start);
    int val [N_CONV];
    int trials [N_CONV];
    int sum, avg, exp_res, busy_exp, c, wr_cycle, k, ci, cum, first_code;
    logic exp_oor;
    logic [N_CH-1:0] exp_en;
    sum = 0; busy_exp = 0; exp_oor = 1'b1;
    for (int i = 0; i < N_CONV; i++) begin
      int t;
      t = thr_tab[i];
      val[i] = (t < 0) ? 0 : ((t > VMAX) ? VMAX : t);
      if (m) begin
        trials[i] = N_VDAC;
        exp_oor = exp_oor & (val[i] == 0);
      end else begin
        trials[i] = (t < 0) ? (VMAX + 1) : (VMAX - val[i] + 1);
        exp_oor = exp_oor & (t < 0);
      end
      sum += val[i];
      busy_exp += 4 * trials[i];
    end
    avg = sum / N_CONV;
    wr_cycle = wr_cycle_in;
    if (wr_cycle == 0) wr_cycle = $urandom_range(1, busy_exp);
    if (wr_cycle == -2) wr_cycle = busy_exp;
    if (wr_cycle > 0 && wr_cycle < busy_exp) lut_m[wr_addr] = wr_data;
    exp_res = cal ? lut_m[avg] : avg;
    exp_en = N_CH'(1 << ch);
    first_code = m ? (1 << (N_VDAC - 1)) : VMAX;

    mode = m; ch_sel = 1'(ch); cal_ena = cal; start = 1'b1;
    @(negedge clk);
    start = 1'b0; mode = ~m; ch_sel = ~1'(ch); cal_ena = ~cal;
    c = 0;
    for (int guard = 0; guard < 3000; guard++) begin
      if (done || !busy) break;
      c++;
      checks++;
      if (dac_en !== exp_en) begin
        errors++; $display("FAIL dac_en cycle %0d got %b expected %b", c, dac_en, exp_en);
      end
      if (c <= 3) begin
        checks++;
        if ((c == 1 && !(dac_data === N_VDAC'(VMAX) && precharge_n === 1'b0)) ||
            (c == 2 && !(dac_data === '0 && precharge_n === 1'b0)) ||
            (c == 3 && !(dac_data === N_VDAC'(first_code) && precharge_n === 1'b1))) begin
          errors++; $display("FAIL phase cycle %0d got dac=%0d pc=%b", c, dac_data, precharge_n);
        end
      end
      k = (c - 1) / 4;
      ci = 0; cum = trials[0];
      while (k >= cum && ci < N_CONV - 1) begin ci++; cum += trials[ci]; end
      cur_thr = thr_tab[ci];
      cal_we = (c == wr_cycle); cal_addr = N_VDAC'(wr_addr); cal_wdata = N_VDAC'(wr_data);
      start = (c == mid_start);
      @(negedge clk);
    end
    cal_we = 1'b0; start = 1'b0;
    checks++;
    if (done !== 1'b1 || busy !== 1'b0) begin
      errors++; $display("FAIL done_pulse got done=%b busy=%b expected done=1 busy=0", done, busy);
    end
    checks++;
    if (c != busy_exp) begin
      errors++; $display("FAIL busy_len got %0d expected %0d", c, busy_exp);
    end
    checks++;
    if (result !== N_VDAC'(exp_res)) begin
      errors++; $display("FAIL result got %0d expected %0d", result, exp_res);
    end
    checks++;
    if (out_of_range !== exp_oor) begin
      errors++; $display("FAIL out_of_range got %b expected %b", out_of_range, exp_oor);
    end
    checks++;
    if (dac_en !== '0 || dac_data !== N_VDAC'(VMAX) || precharge_n !== 1'b0) begin
      errors++; $display("FAIL done_outputs got en=%b dac=%0d pc=%b", dac_en, dac_data, precharge_n);
    end
    if (wr_cycle == busy_exp) lut_m[wr_addr] = wr_data;
  endtask

  task automatic idle_gap();
    repeat (2) @(negedge clk);
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || dac_en !== '0 || dac_data !== N_VDAC'(VMAX) || precharge_n !== 1'b0) begin
      errors++; $display("FAIL idle got busy=%b done=%b en=%b dac=%0d pc=%b", busy, done, dac_en, dac_data, precharge_n);
    end
  endtask

  task automatic set_thr(input int a, input int b, input int c, input int d);
    thr_tab[0] = a; thr_tab[1] = b; thr_tab[2] = c; thr_tab[3] = d;
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; mode = 1'b0; ch_sel = '0; cal_ena = 1'b0;
    cal_we = 1'b0; cal_addr = '0; cal_wdata = '0;
    repeat (3) @(negedge clk);
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || dac_en !== '0 || dac_data !== N_VDAC'(VMAX) ||
        precharge_n !== 1'b0 || result !== '0 || out_of_range !== 1'b0) begin
      errors++; $display("FAIL reset_state got busy=%b done=%b en=%b dac=%0d pc=%b res=%0d oor=%b",
                         busy, done, dac_en, dac_data, precharge_n, result, out_of_range);
    end
    reset = 1'b0;
    lut_model_reset();
    @(negedge clk);
  endtask

  task automatic test_sar_basic();
    set_thr(37, 37, 37, 37);
    do_conv(MODE_SAR, 0, 1'b0, -1, 0, 0, -1);
    @(negedge clk);
    checks++;
    if (done !== 1'b0 || result !== 6'd37) begin
      errors++; $display("FAIL result_hold got done=%b result=%0d expected done=0 result=37", done, result);
    end
    idle_gap();
  endtask

  task automatic test_linear();
    set_thr(37, 37, 37, 37);
    do_conv(MODE_LINEAR, 0, 1'b0, -1, 0, 0, -1);
    idle_gap();
    set_thr(0, 0, 0, 0);
    do_conv(MODE_LINEAR, 1, 1'b0, -1, 0, 0, -1);
    idle_gap();
    set_thr(VMAX, VMAX, VMAX, VMAX);
    do_conv(MODE_SAR, 1, 1'b0, -1, 0, 0, -1);
    idle_gap();
  endtask

  task automatic test_stuck();
    set_thr(-1, -1, -1, -1);
    do_conv(MODE_LINEAR, 1, 1'b0, -1, 0, 0, -1);
    idle_gap();
    do_conv(MODE_SAR, 1, 1'b0, -1, 0, 0, -1);
    idle_gap();
    set_thr(-1, 20, -1, -1);
    do_conv(MODE_SAR, 0, 1'b0, -1, 0, 0, -1);
    idle_gap();
  endtask

  task automatic test_sar_varying();
    set_thr(36, 37, 38, 39);
    do_conv(MODE_SAR, 0, 1'b0, -1, 0, 0, 40);
    idle_gap();
  endtask

  task automatic test_cal();
    set_thr(37, 37, 37, 37);
    do_conv(MODE_SAR, 1, 1'b1, 30, 37, 20, -1);
    idle_gap();
    do_conv(MODE_SAR, 0, 1'b1, -2, 37, 5, -1);
    idle_gap();
    do_conv(MODE_SAR, 0, 1'b1, -1, 0, 0, -1);
    idle_gap();
  endtask

  task automatic test_back_to_back();
    set_thr(10, 11, 12, 13);
    do_conv(MODE_SAR, 1, 1'b0, -1, 0, 0, -1);
    set_thr(50, 50, 51, 51);
    do_conv(MODE_LINEAR, 0, 1'b0, -1, 0, 0, -1);
    set_thr(63, 62, 61, 60);
    do_conv(MODE_SAR, 0, 1'b0, -1, 0, 0, -1);
    idle_gap();
  endtask

  task automatic test_reset_mid();
    set_thr(37, 37, 37, 37);
    mode = MODE_SAR; ch_sel = 1'b1; cal_ena = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (50) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || dac_en !== '0 || dac_data !== N_VDAC'(VMAX) ||
        precharge_n !== 1'b0 || result !== '0 || out_of_range !== 1'b0) begin
      errors++; $display("FAIL reset_mid got busy=%b done=%b en=%b dac=%0d pc=%b res=%0d",
                         busy, done, dac_en, dac_data, precharge_n, result);
    end
    reset = 1'b0;
    lut_model_reset();
    @(negedge clk);
    do_conv(MODE_SAR, 0, 1'b1, -1, 0, 0, -1);
    idle_gap();
  endtask

  task automatic test_random();
    for (int it = 0; it < 8; it++) begin
      for (int i = 0; i < N_CONV; i++)
        thr_tab[i] = ($urandom_range(0, 7) == 0) ? -1 : int'($urandom_range(0, VMAX));
      do_conv(1'($urandom_range(0, 1)), int'($urandom_range(0, N_CH - 1)), 1'($urandom_range(0, 1)),
              ($urandom_range(0, 1) == 1) ? 0 : -1, int'($urandom_range(0, VMAX)),
              int'($urandom_range(0, VMAX)), -1);
      idle_gap();
    end
  endtask

  initial begin
    test_reset();
    test_sar_basic();
    test_linear();
    test_stuck();
    test_sar_varying();
    test_cal();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
